// File: rtl/vga_pkg.sv
// Shared VGA timing constants, RGB332 pixel payload and line-fetch FSM states.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_TOTAL  = 525;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/vga_line_buffer_2bank.sv
// Two-bank line buffer: one synchronous write port, one asynchronous read port.
module vga_line_buffer_2bank
    import vga_pkg::*;
#(
    parameter int unsigned FB_W = 160
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic                    i_wr_bank,
    input  logic [$clog2(FB_W)-1:0] i_wr_idx,
    input  rgb332_t                 i_wr_data,
    input  logic                    i_rd_bank,
    input  logic [$clog2(FB_W)-1:0] i_rd_idx,
    output rgb332_t                 o_rd_data_c
);

    rgb332_t r_mem [2][FB_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_bank][i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data_c = r_mem[i_rd_bank][i_rd_idx];

endmodule

// File: rtl/vga_line_fetcher.sv
// Fetches framebuffer rows into a ping-pong line buffer and emits upscaled
// RGB332 pixels one clock behind hcount/vcount.
module vga_line_fetcher
    import vga_pkg::*;
#(
    parameter int unsigned FB_W   = 160,
    parameter int unsigned FB_H   = 120,
    parameter int unsigned SCALE  = 4,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic [7:0]        final_pixel,
    output logic              underrun
);

    localparam int unsigned SHIFT = $clog2(SCALE);
    localparam int unsigned IDX_W = $clog2(FB_W);
    localparam int unsigned ROW_W = $clog2(FB_H + 1);

    fetch_state_t      r_state, w_state_n;
    logic [IDX_W-1:0]  r_col, w_col_n;
    logic [ADDR_W-1:0] r_addr, w_addr_n;
    logic              r_req, w_req_n;
    logic              r_fill_done, w_fill_n;
    logic              r_disp_bank, w_bank_n;
    logic              r_underrun, w_under_n;
    logic              r_start_pend, w_pend_n;
    logic [ROW_W-1:0]  r_pend_row, w_pend_row_n;
    rgb332_t           r_pixel;

    logic              w_active;
    logic [10:0]       w_vnext;
    logic              w_row_edge;
    logic              w_swap;
    logic [10:0]       w_next_src;
    logic [10:0]       w_follow_row;
    logic              w_follow_ok;
    logic              w_prefetch;
    logic              w_ack;
    logic [IDX_W-1:0]  w_disp_col;
    rgb332_t           w_rd_data;

    function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] row);
        return ADDR_W'(32'(row) * FB_W);
    endfunction

    // Line-boundary decode: swap before each new source row and before line 0.
    assign w_active     = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
    assign w_vnext      = 11'(vcount) + 11'd1;
    assign w_row_edge   = (w_vnext & 11'(SCALE - 1)) == 11'd0;
    assign w_swap       = (hcount == 10'(H_TOTAL - 1)) &&
                          ((w_row_edge && (w_vnext < 11'(V_ACTIVE))) ||
                           (vcount == 10'(V_TOTAL - 1)));
    assign w_next_src   = (vcount == 10'(V_TOTAL - 1)) ? 11'd0 : (w_vnext >> SHIFT);
    assign w_follow_row = w_next_src + 11'd1;
    assign w_follow_ok  = w_follow_row < 11'(FB_H);
    assign w_prefetch   = (vcount == 10'(V_ACTIVE)) && (hcount == 10'd0);
    assign w_ack        = (r_state == ST_FETCH) && r_req && mem_ack && !w_swap;
    assign w_disp_col   = IDX_W'(hcount >> SHIFT);

    always_comb begin
        w_state_n    = r_state;
        w_col_n      = r_col;
        w_addr_n     = r_addr;
        w_req_n      = r_req;
        w_fill_n     = r_fill_done;
        w_bank_n     = r_disp_bank;
        w_under_n    = r_underrun;
        w_pend_n     = 1'b0;
        w_pend_row_n = r_pend_row;

        unique case (r_state)
            ST_FETCH: begin
                if (w_ack) begin
                    if (r_col == IDX_W'(FB_W - 1)) begin
                        w_state_n = ST_DONE;
                        w_req_n   = 1'b0;
                        w_fill_n  = 1'b1;
                    end else begin
                        w_col_n  = r_col + IDX_W'(1);
                        w_addr_n = r_addr + ADDR_W'(1);
                    end
                end
            end
            default: ;
        endcase

        if (r_start_pend || w_prefetch) begin
            w_state_n = ST_FETCH;
            w_col_n   = '0;
            w_req_n   = 1'b1;
            w_fill_n  = 1'b0;
            w_addr_n  = w_prefetch ? '0 : row_base(r_pend_row);
        end

        // A late fill keeps the old bank on screen and flags the miss.
        if (w_swap) begin
            w_state_n    = ST_IDLE;
            w_req_n      = 1'b0;
            w_fill_n     = 1'b0;
            w_pend_n     = w_follow_ok;
            w_pend_row_n = ROW_W'(w_follow_row);
            if (r_fill_done) begin
                w_bank_n = ~r_disp_bank;
            end else begin
                w_under_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_col        <= '0;
            r_addr       <= '0;
            r_req        <= 1'b0;
            r_fill_done  <= 1'b0;
            r_disp_bank  <= 1'b0;
            r_underrun   <= 1'b0;
            r_start_pend <= 1'b0;
            r_pend_row   <= '0;
            r_pixel      <= '0;
        end else begin
            r_state      <= w_state_n;
            r_col        <= w_col_n;
            r_addr       <= w_addr_n;
            r_req        <= w_req_n;
            r_fill_done  <= w_fill_n;
            r_disp_bank  <= w_bank_n;
            r_underrun   <= w_under_n;
            r_start_pend <= w_pend_n;
            r_pend_row   <= w_pend_row_n;
            r_pixel      <= w_active ? w_rd_data : '0;
        end
    end

    vga_line_buffer_2bank #(
        .FB_W (FB_W)
    ) u_lbuf (
        .clk         (clk),
        .i_we        (w_ack && !rst),
        .i_wr_bank   (~r_disp_bank),
        .i_wr_idx    (r_col),
        .i_wr_data   (rgb332_t'(mem_data)),
        .i_rd_bank   (r_disp_bank),
        .i_rd_idx    (w_disp_col),
        .o_rd_data_c (w_rd_data)
    );

    assign mem_req     = r_req;
    assign mem_addr    = r_addr;
    assign final_pixel = r_pixel;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Scoreboard bench for vga_line_fetcher with a bench-driven timing generator and memory model.
module tb_vga_line_fetcher;

    localparam int unsigned FB_W   = 160;
    localparam int unsigned ADDR_W = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [9:0]        hcount = '0;
    logic [9:0]        vcount = '0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack = 1'b0;
    logic [7:0]        mem_data = '0;
    logic [7:0]        final_pixel;
    logic              underrun;

    always #5 clk = ~clk;

    vga_line_fetcher #(
        .FB_W   (160),
        .FB_H   (120),
        .SCALE  (4),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hcount      (hcount),
        .vcount      (vcount),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .final_pixel (final_pixel),
        .underrun    (underrun)
    );

    int          n_checks = 0;
    int          n_err    = 0;
    int unsigned h = 100;
    int unsigned v = 100;
    int          cyc = 0;
    int          ack_mode = 0;   // 0: always, 1: every other cycle, 2: never
    bit          pix_chk = 1'b0;
    bit          addr_chk = 1'b0;
    int          row_mode = 0;   // 0: row = v/SCALE, 1: row 0 held on screen
    logic [7:0]  pix_q [$];
    int unsigned addr_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int unsigned hh, input int unsigned vv);
        int unsigned row;
        if (hh >= 640 || vv >= 480) return 8'h00;
        row = (row_mode == 1) ? 0 : vv / 4;
        return 8'((row * FB_W + hh / 4) & 255);
    endfunction

    task automatic push_row(input int unsigned row);
        for (int c = 0; c < int'(FB_W); c++) addr_q.push_back(row * FB_W + c);
    endtask

    // One pixel clock: drive counts, clock, score pixel, answer memory, advance counts.
    task automatic step();
        bit          pushed;
        int unsigned ea;
        int unsigned sh, sv;
        hcount = 10'(h);
        vcount = 10'(v);
        sh = h;
        sv = v;
        pushed = pix_chk;
        if (pix_chk) pix_q.push_back(exp_pix(h, v));
        @(posedge clk);
        #1;
        cyc++;
        if (pushed) check($sformatf("pixel v%0d h%0d", sv, sh), 32'(final_pixel), 32'(pix_q.pop_front()));
        mem_ack  = mem_req && (ack_mode == 0 || (ack_mode == 1 && (cyc % 2) == 1));
        mem_data = mem_addr[7:0];
        if (addr_chk && mem_req) begin
            if (mem_ack) begin
                ea = (addr_q.size() != 0) ? addr_q.pop_front() : 32'hFFFF_FFFF;
                check("mem_addr", 32'(mem_addr), ea);
            end else if (addr_q.size() != 0) begin
                check("addr_hold", 32'(mem_addr), addr_q[0]);
            end
        end
        if (h == 799) begin
            h = 0;
            v = (v == 524) ? 0 : v + 1;
        end else begin
            h++;
        end
    endtask

    task automatic run_until(input int unsigned tv, input int unsigned th);
        int n = 0;
        while (!(v == tv && h == th) && n < 20000) begin
            step();
            n++;
        end
        if (!(v == tv && h == th)) check("run_until", 32'(v * 1000 + h), 32'(tv * 1000 + th));
    endtask

    initial begin
        int n;

        // Reset at arbitrary counts
        rst = 1'b1;
        step();
        step();
        check("rst_pixel", 32'(final_pixel), 32'h0);
        check("rst_req", 32'(mem_req), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_underrun", 32'(underrun), 32'h0);
        rst = 1'b0;

        // Vblank prefetch of row 0, one ack per clock
        addr_chk = 1'b1;
        ack_mode = 0;
        push_row(0);
        v = 480;
        h = 0;
        step();
        check("pre_req_rise", 32'(mem_req), 32'h1);
        check("pre_addr0", 32'(mem_addr), 32'h0);
        repeat (159) step();
        check("pre_req_held", 32'(mem_req), 32'h1);
        step();
        check("pre_req_drop", 32'(mem_req), 32'h0);
        check("pre_q_empty", 32'(addr_q.size()), 32'h0);

        // Swap into line 0, display rows 0 and 1 while rows 1 and 2 are fetched
        push_row(1);
        push_row(2);
        pix_chk  = 1'b1;
        row_mode = 0;
        h = 790;
        v = 524;
        run_until(8, 0);
        pix_chk = 1'b0;
        check("c_q_empty", 32'(addr_q.size()), 32'h0);
        check("c_underrun", 32'(underrun), 32'h0);

        // Row 3 fetch starts, then reset mid-fetch
        addr_chk = 1'b0;
        ack_mode = 2;
        step();
        check("d_req", 32'(mem_req), 32'h1);
        check("d_addr", 32'(mem_addr), 32'd480);
        step();
        step();
        rst = 1'b1;
        step();
        check("d_rst_req", 32'(mem_req), 32'h0);
        check("d_rst_addr", 32'(mem_addr), 32'h0);
        step();
        check("d_rst_pixel", 32'(final_pixel), 32'h0);
        check("d_rst_underrun", 32'(underrun), 32'h0);
        rst = 1'b0;

        // Underrun: row 1 never acked, row 0 repeats on lines 4..7
        addr_chk = 1'b1;
        ack_mode = 0;
        push_row(0);
        v = 480;
        h = 0;
        repeat (161) step();
        check("e_pre_drop", 32'(mem_req), 32'h0);
        addr_chk = 1'b0;
        ack_mode = 2;
        pix_chk  = 1'b1;
        row_mode = 1;
        h = 790;
        v = 524;
        run_until(3, 799);
        check("e_under_before", 32'(underrun), 32'h0);
        step();
        check("e_under_set", 32'(underrun), 32'h1);
        ack_mode = 0;
        run_until(8, 0);
        pix_chk = 1'b0;
        check("e_under_hold", 32'(underrun), 32'h1);
        h = 780;
        v = 524;
        run_until(0, 10);
        check("e_under_frame", 32'(underrun), 32'h1);

        // Slow memory (ack every other cycle) and full-line blanking
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("f_rst_underrun", 32'(underrun), 32'h0);
        addr_chk = 1'b1;
        ack_mode = 1;
        push_row(0);
        v = 480;
        h = 0;
        step();
        n = 1;
        while (mem_req && n < 400) begin
            step();
            n++;
        end
        check("f_req_drop", 32'(mem_req), 32'h0);
        check("f_cycles", 32'(n >= 319 && n <= 322), 32'h1);
        push_row(1);
        pix_chk  = 1'b1;
        row_mode = 0;
        h = 790;
        v = 524;
        run_until(1, 0);
        pix_chk = 1'b0;
        check("f_underrun", 32'(underrun), 32'h0);
        check("f_q_empty", 32'(addr_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
